max7219_scroller: RTL and testbench
===================================

Name: max7219_scroller

Overview:
- Message scroller for a chain of MAX7219-driven 8x8 LED matrices.
- Holds message column bytes in an internal RAM that a host writes. On command it streams successive display frames to an external MAX7219 serial-interface block, shifting the visible window one column per frame.
- Sits between the host register/RAM bus and the MAX7219 serializer.

Parameters:
- G_MATRIX_NB, 8, number of cascaded matrices (window = G_MATRIX_NB*8 columns).
- G_RAM_ADDR_WIDTH, 8, internal RAM address width (depth 2**G_RAM_ADDR_WIDTH).
- G_RAM_DATA_WIDTH, 8, RAM word width; one word = one 8-LED column, bit0 = top LED.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous active-high reset.
- i_me  in  1  host RAM enable.
- i_we  in  1  host write enable (1 = write, 0 = read).
- i_addr  in  G_RAM_ADDR_WIDTH  host RAM address.
- i_wdata  in  G_RAM_DATA_WIDTH  host write data.
- o_rdata  out  G_RAM_DATA_WIDTH  host read data.
- i_ram_start_ptr  in  G_RAM_ADDR_WIDTH  RAM address of message column 0.
- i_msg_length  in  8  message length in columns.
- i_start_scroll  in  1  start request.
- i_max_tempo_cnt  in  32  inter-frame delay in clk cycles.
- i_max7219_if_done  in  1  serializer finished current word (1-cycle pulse).
- o_max7219_if_start  out  1  serializer start pulse.
- o_max7219_if_en_load  out  1  pulse LOAD after this word.
- o_max7219_if_data  out  16  MAX7219 word {4'h0, addr[3:0], data[7:0]}.
- o_busy  out  1  scroll in progress.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, offset/counters 0. RAM contents are not cleared.
- Host port:
  - write: RAM[i_addr] <= i_wdata when i_me & i_we.
  - read: o_rdata <= RAM[i_addr] when i_me & !i_we; 1-cycle latency; otherwise holds.
  - Allowed while busy; writes affect later column reads.
  - Internal read uses a separate port; no arbitration.
- Start:
  - Accepted only in IDLE with i_start_scroll=1 and i_msg_length!=0.
  - Latches start_ptr, length and tempo; offset=0; o_busy=1 the next cycle.
  - Start is ignored while busy or when length=0.
- Frame for offset o:
  - For digit d=0..7 (register addr d+1), for matrix m=G_MATRIX_NB-1 down to 0, send one word.
  - Column c = m*8+d.
  - data = RAM[(start_ptr + ((o+c) mod length)) mod 2**G_RAM_ADDR_WIDTH]. The message wraps within length; the address wraps within RAM.
  - en_load=1 only on the matrix-0 word of each digit.
  - 8*G_MATRIX_NB words per frame.
- Word handshake:
  - RD_COL: issue RAM read; data valid next cycle.
  - SEND: o_max7219_if_start=1 for exactly one cycle. data/en_load are driven that cycle and held until done.
  - WAIT_DONE: wait for i_max7219_if_done. The next start is no earlier than the cycle after done.
- States: IDLE -> (INIT) -> RD_COL -> SEND -> WAIT_DONE -> RD_COL (more words in frame) | TEMPO (frame done, o<length-1) | IDLE (frame done, o=length-1).
- TEMPO: counts i_max_tempo_cnt cycles (0 = no wait), then o<=o+1 and goes to RD_COL.
- End of scroll: one full pass = length frames. o_busy falls the cycle after the last done of the frame with o=length-1; no tempo after the last frame.
- Length < window: columns repeat (modulo). Length 1: every column = RAM[start_ptr].
- rst mid-operation: abort immediately; start=0, en_load=0, busy=0 next cycle. A pending serializer done is ignored.

Optional Feature:
- Macro MAX7219_SCROLLER_INIT_EN.
- Defined: after start acceptance, INIT state sends these configuration words, each broadcast to all matrices (G_MATRIX_NB words, en_load on the last):
  - 0x0900 (no decode)
  - 0x0A08 (intensity 8)
  - 0x0B07 (scan 8 digits)
  - 0x0C01 (normal operation)
  - 0x0F00 (test off)
- Defined: INIT uses the same start/done handshake and adds 5*G_MATRIX_NB words before the first frame.
- Not defined: INIT is absent and the first word after start is the first frame word.

Test Plan:
- Host write RAM[0x20]=0xA5, then read 0x20 -> o_rdata=0xA5 one cycle after the read request; no read -> o_rdata holds.
- RAM[0x10+i]=i+1 (i=0..63), start_ptr=0x10, length=64, tempo=10, serializer model -> first frame words 0x0139 ... 0x0101, en_load on 0x0101. Total 64 frames x 64 words; busy drops after the last done.
- length=3, start_ptr=0xFE, RAM[0xFE]=1, RAM[0xFF]=2, RAM[0x00]=3 -> frame0 column c data = ((c mod 3)+1), RAM address wraps 0xFF->0x00; 3 frames, then IDLE.
- i_msg_length=0 with start=1 -> busy stays 0, no start pulses; start=1 while busy -> no restart, offset unchanged.
- rst asserted during WAIT_DONE of frame 2 -> outputs 0 next cycle; new start then begins at offset 0 with RAM contents intact.
- With MAX7219_SCROLLER_INIT_EN, G_MATRIX_NB=8 -> first 40 words are the config words (8 x 0x0900 ... 8 x 0x0F00), en_load on every 8th, then frame 0.

Source files
------------

// File: rtl/max7219_scroller.sv
// max7219_scroller: scrolls a RAM-held message across cascaded MAX7219 8x8 matrices (rev 1.0).
// Optional MAX7219 configuration preamble enabled by defining MAX7219_SCROLLER_INIT_EN.
`timescale 1ns/1ps
`default_nettype none

module max7219_scroller #(
  parameter int G_MATRIX_NB      = 8,
  parameter int G_RAM_ADDR_WIDTH = 8,
  parameter int G_RAM_DATA_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_me,
  input  logic                        i_we,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_addr,
  input  logic [G_RAM_DATA_WIDTH-1:0] i_wdata,
  output logic [G_RAM_DATA_WIDTH-1:0] o_rdata,
  input  logic [G_RAM_ADDR_WIDTH-1:0] i_ram_start_ptr,
  input  logic [7:0]                  i_msg_length,
  input  logic                        i_start_scroll,
  input  logic [31:0]                 i_max_tempo_cnt,
  input  logic                        i_max7219_if_done,
  output logic                        o_max7219_if_start,
  output logic                        o_max7219_if_en_load,
  output logic [15:0]                 o_max7219_if_data,
  output logic                        o_busy
);

  localparam int MAT_W = (G_MATRIX_NB > 1) ? $clog2(G_MATRIX_NB) : 1;
  localparam logic [MAT_W-1:0] MAT_LAST = MAT_W'(G_MATRIX_NB - 1);
  localparam logic [MAT_W-1:0] MAT_ONE  = MAT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INIT      = 3'd1,
    INIT_WAIT = 3'd2,
    RD_COL    = 3'd3,
    SEND      = 3'd4,
    WAIT_DONE = 3'd5,
    TEMPO     = 3'd6
  } state_t;

  state_t state, state_next;

  logic [G_RAM_DATA_WIDTH-1:0] mem [2**G_RAM_ADDR_WIDTH];
  logic [G_RAM_DATA_WIDTH-1:0] col_data;

  logic [G_RAM_ADDR_WIDTH-1:0] ptr;
  logic [7:0]                  len;
  logic [31:0]                 tempo;
  logic [31:0]                 tempo_cnt;
  logic [7:0]                  offset;
  logic [2:0]                  digit;
  logic [MAT_W-1:0]            mat;
  logic [2:0]                  init_idx;

  logic                        accept;
  logic                        last_mat;
  logic                        last_word;
  logic                        last_frame;
  logic                        tempo_done;
  logic [15:0]                 col_sum;
  logic [15:0]                 col_div;
  logic [15:0]                 col_mod;
  logic [G_RAM_ADDR_WIDTH-1:0] col_addr;

  function automatic logic [15:0] init_word(input logic [2:0] idx);
    case (idx)
      3'd0:    init_word = 16'h0900;
      3'd1:    init_word = 16'h0A08;
      3'd2:    init_word = 16'h0B07;
      3'd3:    init_word = 16'h0C01;
      default: init_word = 16'h0F00;
    endcase
  endfunction

  assign accept     = (state == IDLE) && i_start_scroll && (i_msg_length != 8'd0);
  assign last_mat   = (mat == '0);
  assign last_word  = last_mat && (digit == 3'd7);
  assign last_frame = (offset == len - 8'd1);
  assign tempo_done = (tempo_cnt == tempo - 32'd1);

  // Column index wraps inside the message first, then the RAM address wraps naturally.
  assign col_sum  = 16'(offset) + 16'({mat, digit});
  assign col_div  = (len == 8'd0) ? 16'd1 : {8'h00, len};
  assign col_mod  = col_sum % col_div;
  assign col_addr = ptr + G_RAM_ADDR_WIDTH'(col_mod);

  always_ff @(posedge clk) begin
    if (i_me && i_we) begin
      mem[i_addr] <= i_wdata;
    end
    if (state == RD_COL) begin
      col_data <= mem[col_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_rdata <= '0;
    end else if (i_me && !i_we) begin
      o_rdata <= mem[i_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next           = state;
    o_max7219_if_start   = 1'b0;
    o_max7219_if_en_load = 1'b0;
    o_max7219_if_data    = 16'h0000;
    o_busy               = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef MAX7219_SCROLLER_INIT_EN
          state_next = INIT;
`else
          state_next = RD_COL;
`endif
        end
      end
      INIT: begin
        o_max7219_if_start   = 1'b1;
        o_max7219_if_en_load = last_mat;
        o_max7219_if_data    = init_word(init_idx);
        state_next           = INIT_WAIT;
      end
      INIT_WAIT: begin
        o_max7219_if_en_load = last_mat;
        o_max7219_if_data    = init_word(init_idx);
        if (i_max7219_if_done) begin
          state_next = (last_mat && init_idx == 3'd4) ? RD_COL : INIT;
        end
      end
      RD_COL: begin
        state_next = SEND;
      end
      SEND: begin
        o_max7219_if_start   = 1'b1;
        o_max7219_if_en_load = last_mat;
        o_max7219_if_data    = {4'h0, {1'b0, digit} + 4'd1, col_data[7:0]};
        state_next           = WAIT_DONE;
      end
      WAIT_DONE: begin
        o_max7219_if_en_load = last_mat;
        o_max7219_if_data    = {4'h0, {1'b0, digit} + 4'd1, col_data[7:0]};
        if (i_max7219_if_done) begin
          if (!last_word) begin
            state_next = RD_COL;
          end else if (last_frame) begin
            state_next = IDLE;
          end else if (tempo == 32'd0) begin
            state_next = RD_COL;
          end else begin
            state_next = TEMPO;
          end
        end
      end
      TEMPO: begin
        if (tempo_done) begin
          state_next = RD_COL;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      len       <= 8'd0;
      tempo     <= 32'd0;
      tempo_cnt <= 32'd0;
      offset    <= 8'd0;
      digit     <= 3'd0;
      mat       <= '0;
      init_idx  <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ptr       <= i_ram_start_ptr;
            len       <= i_msg_length;
            tempo     <= i_max_tempo_cnt;
            tempo_cnt <= 32'd0;
            offset    <= 8'd0;
            digit     <= 3'd0;
            mat       <= MAT_LAST;
            init_idx  <= 3'd0;
          end
        end
        INIT_WAIT: begin
          if (i_max7219_if_done) begin
            if (last_mat) begin
              mat      <= MAT_LAST;
              init_idx <= init_idx + 3'd1;
            end else begin
              mat <= mat - MAT_ONE;
            end
          end
        end
        WAIT_DONE: begin
          if (i_max7219_if_done) begin
            if (last_mat) begin
              mat   <= MAT_LAST;
              digit <= digit + 3'd1;
              // Zero tempo skips TEMPO, so the offset advances here instead.
              if (digit == 3'd7 && !last_frame && tempo == 32'd0) begin
                offset <= offset + 8'd1;
              end
            end else begin
              mat <= mat - MAT_ONE;
            end
          end
        end
        TEMPO: begin
          if (tempo_done) begin
            tempo_cnt <= 32'd0;
            offset    <= offset + 8'd1;
          end else begin
            tempo_cnt <= tempo_cnt + 32'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_max7219_scroller.sv
// tb_max7219_scroller: scoreboard bench for max7219_scroller with a fixed-latency serializer model.
`timescale 1ns/1ps
`default_nettype none

module tb_max7219_scroller;

  localparam int NB      = 8;
  localparam int SER_LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        me = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wdata = 8'h00;
  logic [7:0]  rdata;
  logic [7:0]  start_ptr = 8'h00;
  logic [7:0]  msg_len = 8'h00;
  logic        start_scroll = 1'b0;
  logic [31:0] tempo = 32'd0;
  logic        done = 1'b0;
  logic        ser_start;
  logic        en_load;
  logic [15:0] data;
  logic        busy;

  always #5 clk = ~clk;

  max7219_scroller #(
    .G_MATRIX_NB      (NB),
    .G_RAM_ADDR_WIDTH (8),
    .G_RAM_DATA_WIDTH (8)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_me                 (me),
    .i_we                 (we),
    .i_addr               (addr),
    .i_wdata              (wdata),
    .o_rdata              (rdata),
    .i_ram_start_ptr      (start_ptr),
    .i_msg_length         (msg_len),
    .i_start_scroll       (start_scroll),
    .i_max_tempo_cnt      (tempo),
    .i_max7219_if_done    (done),
    .o_max7219_if_start   (ser_start),
    .o_max7219_if_en_load (en_load),
    .o_max7219_if_data    (data),
    .o_busy               (busy)
  );

  typedef struct {
    logic [16:0] word;
    int          gap;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  int          ser_cnt = 0;
  int          word_cnt = 0;
  logic        prev_start = 1'b0;
  logic [16:0] last_word = 17'h0;
  logic [7:0]  model [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor and serializer model share one process so their ordering is fixed.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      ser_cnt    = 0;
      done       = 1'b0;
      prev_start = 1'b0;
    end else begin
      done = 1'b0;
      if (ser_cnt > 0) begin
        check("hold_word", {15'h0, en_load, data}, {15'h0, last_word});
        ser_cnt--;
        if (ser_cnt == 0) begin
          done          = 1'b1;
          last_done_cyc = cyc;
        end
      end
      if (ser_start) begin
        check("start_width", {31'h0, prev_start}, 32'h0);
        check("start_early", {31'h0, (ser_cnt != 0) || done}, 32'h0);
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %0h expected none", {en_load, data});
        end else begin
          mon_e = q.pop_front();
          check("word", {15'h0, en_load, data}, {15'h0, mon_e.word});
          if (mon_e.gap != 0) begin
            check("gap", cyc - last_done_cyc, mon_e.gap);
          end
        end
        word_cnt++;
        ser_cnt   = SER_LAT;
        last_word = {en_load, data};
      end
      prev_start = ser_start;
    end
  end

  task automatic push_frame(input int ptr, input int len, input int o, input int first_gap);
    exp_t       e;
    int         c;
    int         a;
    logic [3:0] dreg;
    for (int d = 0; d < 8; d++) begin
      for (int m = NB - 1; m >= 0; m--) begin
        c      = m * 8 + d;
        a      = (ptr + ((o + c) % len)) % 256;
        dreg   = 4'(d + 1);
        e.word = {(m == 0), 4'h0, dreg, model[a]};
        e.gap  = (d == 0 && m == NB - 1) ? first_gap : SER_LAT;
        q.push_back(e);
      end
    end
  endtask

  task automatic push_scroll(input int ptr, input int len, input int tmp);
    exp_t        e;
    logic [15:0] cfg [5];
    int          g0;
    cfg[0] = 16'h0900;
    cfg[1] = 16'h0A08;
    cfg[2] = 16'h0B07;
    cfg[3] = 16'h0C01;
    cfg[4] = 16'h0F00;
    g0 = 0;
`ifdef MAX7219_SCROLLER_INIT_EN
    for (int i = 0; i < 5; i++) begin
      for (int m = NB - 1; m >= 0; m--) begin
        e.word = {(m == 0), cfg[i]};
        e.gap  = 0;
        q.push_back(e);
      end
    end
    g0 = SER_LAT;
`else
    e.word = {1'b0, cfg[0]};
`endif
    push_frame(ptr, len, 0, g0);
    for (int o = 1; o < len; o++) begin
      push_frame(ptr, len, o, tmp + SER_LAT);
    end
  endtask

  task automatic host_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    me = 1'b1; we = 1'b1; addr = a; wdata = d;
    model[a] = d;
    @(negedge clk);
    me = 1'b0; we = 1'b0;
  endtask

  task automatic begin_scroll(input logic [7:0] p, input logic [7:0] l, input logic [31:0] t);
    push_scroll(int'(p), int'(l), int'(t));
    @(negedge clk);
    start_ptr = p; msg_len = l; tempo = t; start_scroll = 1'b1;
    @(negedge clk);
    start_scroll = 1'b0;
    check("busy_after_start", {31'h0, busy}, 32'h1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within %0d cycles", max_cyc);
    end
    check("queue_empty", q.size(), 32'h0);
  endtask

  task automatic run_scroll(input logic [7:0] p, input logic [7:0] l, input logic [31:0] t);
    int base;
    int words;
    base  = word_cnt;
    words = int'(l) * NB * 8;
`ifdef MAX7219_SCROLLER_INIT_EN
    words += 5 * NB;
`endif
    begin_scroll(p, l, t);
    wait_idle(60000);
    check("word_count", word_cnt - base, words);
  endtask

  initial begin
    int base;
    int n;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_start", {31'h0, ser_start}, 32'h0);
    check("rst_en_load", {31'h0, en_load}, 32'h0);
    check("rst_data", {16'h0, data}, 32'h0);
    check("rst_rdata", {24'h0, rdata}, 32'h0);
    rst = 1'b0;

    // Host port: read latency and hold
    host_write(8'h20, 8'hA5);
    @(negedge clk);
    me = 1'b1; we = 1'b0; addr = 8'h20;
    @(negedge clk);
    me = 1'b0;
    check("host_read", {24'h0, rdata}, 32'hA5);
    host_write(8'h21, 8'h3C);
    addr = 8'h21;
    repeat (2) @(negedge clk);
    check("host_rdata_hold", {24'h0, rdata}, 32'hA5);

    // Full 64-column message, tempo 10
    for (int i = 0; i < 64; i++) begin
      host_write(8'(8'h10 + i), 8'(i + 1));
    end
    run_scroll(8'h10, 8'd64, 32'd10);

    // Short message wrapping through the top of the RAM
    host_write(8'hFE, 8'h01);
    host_write(8'hFF, 8'h02);
    host_write(8'h00, 8'h03);
    run_scroll(8'hFE, 8'd3, 32'd0);

    // Zero length is rejected
    base = word_cnt;
    @(negedge clk);
    start_ptr = 8'h10; msg_len = 8'd0; start_scroll = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("len0_busy", {31'h0, busy}, 32'h0);
    end
    start_scroll = 1'b0;
    repeat (4) @(negedge clk);
    check("len0_words", word_cnt - base, 32'h0);

    // Start while busy is ignored
    begin_scroll(8'hFE, 8'd3, 32'd5);
    repeat (50) @(negedge clk);
    start_ptr = 8'h10; msg_len = 8'd64; start_scroll = 1'b1;
    repeat (3) @(negedge clk);
    start_scroll = 1'b0;
    wait_idle(5000);

    // Reset in WAIT_DONE of frame 2 (offset 2)
    base = word_cnt;
    begin_scroll(8'h10, 8'd64, 32'd0);
    n = 0;
    while (word_cnt < base + 2 * NB * 8 + 5 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reach_frame2", {31'h0, word_cnt >= base + 2 * NB * 8 + 5}, 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_start", {31'h0, ser_start}, 32'h0);
    check("abort_en_load", {31'h0, en_load}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_data", {16'h0, data}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    run_scroll(8'h10, 8'd64, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no completion expected finish before 3000000ns");
    $fatal(1);
  end

endmodule

`default_nettype wire
